// File: rtl/shift_reg_univ.sv
// Universal shift register: parallel load, shift, rotate and invert, plus a
// burst mode that serialises the whole register out of sout_r, LSB first.
module shift_reg_univ #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  localparam int unsigned     CntW    = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    unique case (state_q)
      StIdle: begin
        // start wins over any mode operation requested in the same cycle
        if (start) begin
          state_d = StShift;
          cnt_d   = '0;
        end else if (en) begin
          case (mode)
            3'b001:  q_d = d;
            3'b010:  q_d = {q_q[WIDTH-2:0], sin_r};
            3'b011:  q_d = {sin_l, q_q[WIDTH-1:1]};
            3'b100:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            3'b101:  q_d = {q_q[0], q_q[WIDTH-1:1]};
            3'b110:  q_d = ~q_q;
            default: q_d = q_q;
          endcase
        end
      end
      StShift: begin
        q_d   = {sin_l, q_q[WIDTH-1:1]};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      q_q     <= RESET_VAL;
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      q_q     <= q_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign q      = q_q;
  assign qb     = ~q_q;
  assign sout_l = q_q[WIDTH-1];
  assign sout_r = q_q[0];
  assign busy   = (state_q == StShift);
  assign done   = (state_q == StDone);

endmodule

// File: doc/shift_reg_univ.md
SHIFT_REG_UNIV -- requirements
Module: shift_reg_univ

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits (legal range 2..32).
REQ-002 SHALL have parameter RESET_VAL, default 0, value loaded into q on clear.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port clear  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en  input  1  enables a mode operation in the current cycle.
REQ-006 SHALL have port mode  input  3  operation select, see REQ-012.
REQ-007 SHALL have port d  input  WIDTH  parallel load data.
REQ-008 SHALL have ports sin_l, sin_r  input  1 each  serial data into MSB (right shifts) and LSB (left shifts).
REQ-009 SHALL have port start  input  1  burst-serialise request.
REQ-010 SHALL have ports q, qb  output  WIDTH each  register value and its bitwise complement.
REQ-011 SHALL have ports sout_l, sout_r, busy, done  output  1 each  q[WIDTH-1], q[0], burst active, burst-complete pulse.

Function
REQ-012 SHALL decode mode when en=1 and FSM is IDLE:
- 000 hold
- 001 load: q<=d
- 010 shift left: q<={q[WIDTH-2:0],sin_r}
- 011 shift right: q<={sin_l,q[WIDTH-1:1]}
- 100 rotate left
- 101 rotate right
- 110 invert: q<=~q
- 111 hold
REQ-013 SHALL hold q whenever en=0 and FSM is IDLE.
REQ-014 SHALL drive qb = ~q, sout_l = q[WIDTH-1], sout_r = q[0] combinationally at all times, including during reset.
REQ-015 SHALL implement a FSM with states IDLE, SHIFT, DONE.
REQ-016 SHALL leave IDLE for SHIFT on a cycle with start=1; start SHALL have priority over en/mode in that cycle, and q SHALL NOT change in that cycle.
REQ-017 SHALL perform exactly WIDTH right shifts in SHIFT, one per cycle, with sin_l entering the MSB, regardless of en.
- A counter SHALL track the shifts; counter width is $clog2(WIDTH+1).
REQ-018 SHALL transition SHIFT->DONE after the WIDTH-th shift, and DONE->IDLE unconditionally after one cycle.
REQ-019 SHALL ignore en, mode, start and d while in SHIFT or DONE; q SHALL hold in DONE.
REQ-020 SHALL assert busy=1 exactly in SHIFT, i.e. for WIDTH consecutive cycles.
REQ-021 SHALL assert done=1 exactly in DONE, as a one-cycle pulse.
REQ-022 SHALL accept a start that arrives in DONE's following IDLE cycle; the earliest back-to-back burst begins one cycle after done.
REQ-023 SHALL present the original q[0] on sout_r during the first busy cycle and original q[k] during busy cycle k+1, LSB first.

Reset
REQ-024 SHALL have clear take priority over every other input on the clock edge on which it is sampled high.
REQ-025 SHALL on clear: q<=RESET_VAL, FSM<=IDLE, counter<=0, busy=0, done=0.
REQ-026 SHALL abort a burst when clear is asserted mid-SHIFT, with no done pulse.
REQ-027 SHALL leave outputs unknown only before the first clear edge; a bench SHALL assert clear at time 0.

Verification
REQ-028 SHALL verify, with WIDTH=8: clear=1 for 1 edge -> q=8'h00, qb=8'hFF, busy=0, done=0.
REQ-029 SHALL verify: en=1, mode=001, d=8'hA5 -> q=8'hA5; then mode=010, sin_r=1 -> q=8'h4B; then mode=101 -> q=8'hA5; then mode=110 -> q=8'h5A.
REQ-030 SHALL verify: en=0 with mode=001 and d=8'hFF for 3 edges -> q unchanged.
REQ-031 SHALL verify: q=8'hC3, start pulse, sin_l=0 ->
- busy high 8 cycles, sout_r sequence 1,1,0,0,0,0,1,1
- then done for 1 cycle, q=8'h00
- busy and done never overlap
REQ-032 SHALL verify: start, then clear after 3 busy cycles -> q=RESET_VAL next edge, busy=0, no done pulse; mode ops work next cycle.
REQ-033 SHALL verify: start and en=1 with mode=001 in the same idle cycle -> burst starts, q not loaded.
